// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
//
// Purpose:
//   Decouples a dual-issue instruction fetch stage from decode. Fetch delivers
//   up to two (PC, instruction) pairs per cycle. Decode consumes up to two
//   entries per cycle from the head of the queue. The head and head+1 entries
//   are always presented combinationally (show-ahead), so decode can look at
//   them before deciding how many to consume.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   resetn       - asynchronous active-low reset
//   flush        - discards every buffered entry (branch redirect/exception)
//   in_valid1/2  - fetch slot 1 / slot 2 carry an instruction
//   in_pc1/2     - PC of fetch slot 1 / slot 2
//   in_inst1/2   - instruction word of fetch slot 1 / slot 2
//   pop_cnt      - entries decode consumes this cycle (0..2, 3 acts as 2)
//   out_valid1/2 - head / head+1 entry present
//   out_pc1/2    - PC of head / head+1 entry (0 when not valid)
//   out_inst1/2  - instruction of head / head+1 entry (0 when not valid)
//   fetch_stall  - fewer than two free entries remain
//   count        - current occupancy
//   overflow     - sticky flag, set when a pushed entry had to be dropped
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       in_valid1,
    input  logic                       in_valid2,
    input  logic [31:0]                in_pc1,
    input  logic [31:0]                in_inst1,
    input  logic [31:0]                in_pc2,
    input  logic [31:0]                in_inst2,
    input  logic [1:0]                 pop_cnt,
    output logic                       out_valid1,
    output logic                       out_valid2,
    output logic [31:0]                out_pc1,
    output logic [31:0]                out_inst1,
    output logic [31:0]                out_pc2,
    output logic [31:0]                out_inst2,
    output logic                       fetch_stall,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // DEPTH itself must be representable in the occupancy counter, which is
    // why the counter carries one bit more than the pointers.
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Entry storage. Deliberately not reset: validity is tracked entirely by
    // the pointers and the occupancy counter.
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr_p1;
    logic [AW-1:0] wptr_p1;

    logic [1:0]    push_n;
    logic [1:0]    pop_req;
    logic [1:0]    pop_eff;
    logic [1:0]    push_acc;
    logic [CW-1:0] free_cnt;
    logic          push_drop;

    assign rptr_p1 = rptr + AW'(1);
    assign wptr_p1 = wptr + AW'(1);

    // Free space is measured against the registered occupancy, before this
    // cycle's pop. A pop therefore never makes room for a push in the same
    // cycle, which keeps the accept logic independent of decode timing.
    assign free_cnt = DEPTH_C - count;

    // Push/pop bookkeeping. Slot 2 is only meaningful when slot 1 is valid,
    // so a lone in_valid2 is ignored. When space runs short slot 1 wins,
    // preserving program order. Pop requests are clamped to what is held.
    always_comb begin
        push_n    = 2'd0;
        pop_req   = 2'd0;
        pop_eff   = 2'd0;
        push_acc  = 2'd0;
        push_drop = 1'b0;

        if (in_valid1) begin
            push_n = in_valid2 ? 2'd2 : 2'd1;
        end

        pop_req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;

        // count can only be below pop_req when it is 0 or 1, so its low two
        // bits are the full value in that branch.
        if (count >= CW'(pop_req)) begin
            pop_eff = pop_req;
        end else begin
            pop_eff = count[1:0];
        end

        // Same reasoning: free_cnt < push_n implies free_cnt <= 1.
        if (free_cnt >= CW'(push_n)) begin
            push_acc = push_n;
        end else begin
            push_acc = free_cnt[1:0];
        end

        push_drop = (push_acc != push_n);
    end

    // Pointer, occupancy and overflow state. Flush outranks push and pop and
    // returns everything to the reset arrangement; pushes that arrive with a
    // flush are redirected-away fetches, not errors, so they leave overflow
    // clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wptr  <= wptr + AW'(push_acc);
            rptr  <= rptr + AW'(pop_eff);
            count <= count + CW'(push_acc) - CW'(pop_eff);
            if (push_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Entry writes. Slot 1 lands at wptr and slot 2 right after it, which
    // keeps program order through the wrap. Suppressed during flush so a
    // redirected fetch never leaves stale data behind the write pointer.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_acc != 2'd0) begin
                pc_mem[wptr]   <= in_pc1;
                inst_mem[wptr] <= in_inst1;
            end
            if (push_acc == 2'd2) begin
                pc_mem[wptr_p1]   <= in_pc2;
                inst_mem[wptr_p1] <= in_inst2;
            end
        end
    end

    // Show-ahead outputs. Everything here derives from registered state, so
    // data pushed this cycle appears only after the next edge and the async
    // reset clears the valids immediately through count.
    assign out_valid1 = (count != '0);
    assign out_valid2 = (count >= CW'(2));

    assign out_pc1   = out_valid1 ? pc_mem[rptr]      : 32'd0;
    assign out_inst1 = out_valid1 ? inst_mem[rptr]    : 32'd0;
    assign out_pc2   = out_valid2 ? pc_mem[rptr_p1]   : 32'd0;
    assign out_inst2 = out_valid2 ? inst_mem[rptr_p1] : 32'd0;

    // Stall is a pure function of the registered count, so fetch never sees
    // a combinational loop through decode's pop_cnt.
    assign fetch_stall = (free_cnt < CW'(2));

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_buffer
//
// Purpose:
//   Self-checking bench for inst_fetch_buffer (DEPTH = 16). Directed stimulus
//   pushes the entries it expects decode to receive into a scoreboard queue;
//   an independent monitor pops that queue whenever the DUT presents a head
//   entry that decode consumes, and compares PC and instruction. Occupancy,
//   stall and overflow are checked against hand-computed values after each
//   interesting step.
// ---------------------------------------------------------------------------
module tb_inst_fetch_buffer;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic          in_valid1;
    logic          in_valid2;
    logic [31:0]   in_pc1;
    logic [31:0]   in_inst1;
    logic [31:0]   in_pc2;
    logic [31:0]   in_inst2;
    logic [1:0]    pop_cnt;
    logic          out_valid1;
    logic          out_valid2;
    logic [31:0]   out_pc1;
    logic [31:0]   out_inst1;
    logic [31:0]   out_pc2;
    logic [31:0]   out_inst2;
    logic          fetch_stall;
    logic [CW-1:0] count;
    logic          overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t exp_q[$];

    inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid1   (in_valid1),
        .in_valid2   (in_valid2),
        .in_pc1      (in_pc1),
        .in_inst1    (in_inst1),
        .in_pc2      (in_pc2),
        .in_inst2    (in_inst2),
        .pop_cnt     (pop_cnt),
        .out_valid1  (out_valid1),
        .out_valid2  (out_valid2),
        .out_pc1     (out_pc1),
        .out_inst1   (out_inst1),
        .out_pc2     (out_pc2),
        .out_inst2   (out_inst2),
        .fetch_stall (fetch_stall),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Instruction word tied to its PC so a PC/instruction pairing error shows.
    function automatic logic [31:0] instOf(input logic [31:0] pc);
        return {pc[15:0], 16'h0013} ^ 32'hA5A5_0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs at the falling edge, records the entries the
    // buffer is expected to accept, and returns just after the rising edge
    // that consumes those inputs.
    task automatic applyStimulus(input logic v1, input logic [31:0] pc1,
                                 input logic v2, input logic [31:0] pc2,
                                 input logic [1:0] pop, input logic fl,
                                 input int n_acc);
        entry_t e;
        @(negedge clk);
        in_valid1 = v1;
        in_pc1    = pc1;
        in_inst1  = instOf(pc1);
        in_valid2 = v2;
        in_pc2    = pc2;
        in_inst2  = instOf(pc2);
        pop_cnt   = pop;
        flush     = fl;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (n_acc >= 1) begin
                e.pc = pc1; e.inst = instOf(pc1);
                exp_q.push_back(e);
            end
            if (n_acc >= 2) begin
                e.pc = pc2; e.inst = instOf(pc2);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] pop);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, pop, 1'b0, 0);
    endtask

    // Monitor: one time unit before each rising edge, consume the entries
    // decode is taking and compare them with the scoreboard.
    int     mon_n;
    entry_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (resetn === 1'b1 && flush === 1'b0) begin
                mon_n = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
                if (!out_valid1) begin
                    checkOutput("idle out_pc1 zero", out_pc1, 32'd0);
                end
                if (mon_n >= 1 && out_valid1) begin
                    if (exp_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected head: got pc 0x%08h, expected none", out_pc1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("head pc", out_pc1, mon_e.pc);
                        checkOutput("head inst", out_inst1, mon_e.inst);
                    end
                end
                if (mon_n >= 2 && out_valid2) begin
                    if (exp_q.size() == 0) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL unexpected head+1: got pc 0x%08h, expected none", out_pc2);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("head+1 pc", out_pc2, mon_e.pc);
                        checkOutput("head+1 inst", out_inst2, mon_e.inst);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int          pushed;
    int          cycles;
    logic [1:0]  rpop;
    logic [31:0] pc_base;

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
        in_pc1    = '0;
        in_inst1  = '0;
        in_pc2    = '0;
        in_inst2  = '0;
        pop_cnt   = 2'd0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset out_valid1", 32'(out_valid1), 32'd0);
        checkOutput("reset out_valid2", 32'(out_valid2), 32'd0);
        checkOutput("reset fetch_stall", 32'(fetch_stall), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        #2;
        resetn = 1'b1;

        $display("[TB] dual push");
        applyStimulus(1'b1, 32'hBFC0_0000, 1'b1, 32'hBFC0_0004, 2'd0, 1'b0, 2);
        checkOutput("dual count", 32'(count), 32'd2);
        checkOutput("dual out_valid1", 32'(out_valid1), 32'd1);
        checkOutput("dual out_valid2", 32'(out_valid2), 32'd1);
        checkOutput("dual out_pc1", out_pc1, 32'hBFC0_0000);
        checkOutput("dual out_pc2", out_pc2, 32'hBFC0_0004);
        checkOutput("dual out_inst1", out_inst1, instOf(32'hBFC0_0000));
        idle(2'd3);
        checkOutput("pop3 count", 32'(count), 32'd0);
        checkOutput("pop3 out_valid1", 32'(out_valid1), 32'd0);

        $display("[TB] fill and stall");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(8*i), 1'b1, 32'h1004 + 32'(8*i), 2'd0, 1'b0, 2);
        end
        checkOutput("fill14 count", 32'(count), 32'd14);
        checkOutput("fill14 stall", 32'(fetch_stall), 32'd0);
        applyStimulus(1'b1, 32'h1038, 1'b1, 32'h103C, 2'd0, 1'b0, 2);
        checkOutput("fill16 count", 32'(count), 32'd16);
        checkOutput("fill16 stall", 32'(fetch_stall), 32'd1);
        checkOutput("fill16 overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) idle(2'd2);
        checkOutput("drain count", 32'(count), 32'd0);
        checkOutput("drain stall", 32'(fetch_stall), 32'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h4000 + 32'(8*i), 1'b1, 32'h4004 + 32'(8*i), 2'd0, 1'b0, 2);
        end
        applyStimulus(1'b1, 32'h4038, 1'b0, 32'd0, 2'd0, 1'b0, 1);
        checkOutput("fill15 count", 32'(count), 32'd15);
        checkOutput("fill15 stall", 32'(fetch_stall), 32'd1);
        applyStimulus(1'b1, 32'h403C, 1'b1, 32'h4040, 2'd0, 1'b0, 1);
        checkOutput("ovf count", 32'(count), 32'd16);
        checkOutput("ovf flag", 32'(overflow), 32'd1);
        idle(2'd0);
        checkOutput("ovf sticky", 32'(overflow), 32'd1);
        applyStimulus(1'b1, 32'h5000, 1'b1, 32'h5004, 2'd2, 1'b0, 0);
        checkOutput("full push2 pop2 count", 32'(count), 32'd14);
        checkOutput("full push2 pop2 overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 7; i++) idle(2'd2);
        checkOutput("ovf drain count", 32'(count), 32'd0);
        checkOutput("ovf after drain", 32'(overflow), 32'd1);
        applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 2'd0, 1'b1, 0);
        checkOutput("ovf cleared by flush", 32'(overflow), 32'd0);

        $display("[TB] flush priority");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h6000 + 32'(8*i), 1'b1, 32'h6004 + 32'(8*i), 2'd0, 1'b0, 2);
        end
        checkOutput("pre-flush count", 32'(count), 32'd6);
        applyStimulus(1'b1, 32'h7000, 1'b1, 32'h7004, 2'd2, 1'b1, 0);
        checkOutput("flush count", 32'(count), 32'd0);
        checkOutput("flush out_valid1", 32'(out_valid1), 32'd0);
        checkOutput("flush overflow", 32'(overflow), 32'd0);
        idle(2'd0);
        checkOutput("post-flush count", 32'(count), 32'd0);

        $display("[TB] wrap and order stream");
        pushed = 0;
        cycles = 0;
        while (pushed < 40 && cycles < 300) begin
            cycles++;
            rpop    = 2'($urandom_range(0, 2));
            pc_base = 32'h2000 + 32'(4*pushed);
            if (fetch_stall == 1'b0) begin
                if (40 - pushed >= 2) begin
                    applyStimulus(1'b1, pc_base, 1'b1, pc_base + 32'd4, rpop, 1'b0, 2);
                    pushed += 2;
                end else begin
                    applyStimulus(1'b1, pc_base, 1'b0, 32'd0, rpop, 1'b0, 1);
                    pushed += 1;
                end
            end else begin
                idle(rpop);
            end
        end
        checkOutput("stream pushes issued", 32'(pushed), 32'd40);
        for (int i = 0; i < 40 && count != '0; i++) idle(2'd2);
        checkOutput("stream drained count", 32'(count), 32'd0);
        checkOutput("stream scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] async reset");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h8000 + 32'(8*i), 1'b1, 32'h8004 + 32'(8*i), 2'd0, 1'b0, 2);
        end
        applyStimulus(1'b1, 32'h8020, 1'b0, 32'd0, 2'd0, 1'b0, 1);
        checkOutput("pre-reset count", 32'(count), 32'd9);
        resetn = 1'b0;
        #1;
        checkOutput("async count", 32'(count), 32'd0);
        checkOutput("async out_valid1", 32'(out_valid1), 32'd0);
        checkOutput("async out_valid2", 32'(out_valid2), 32'd0);
        checkOutput("async stall", 32'(fetch_stall), 32'd0);
        exp_q.delete();
        #1;
        resetn = 1'b1;
        applyStimulus(1'b1, 32'h9000, 1'b0, 32'd0, 2'd0, 1'b0, 1);
        checkOutput("post-reset count", 32'(count), 32'd1);
        checkOutput("post-reset out_pc1", out_pc1, 32'h9000);
        idle(2'd1);
        checkOutput("final count", 32'(count), 32'd0);
        checkOutput("final scoreboard empty", 32'(exp_q.size()), 32'd0);

        idle(2'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
